// File: rtl/adc_to_axis_master.sv
// adc_to_axis_master
// Drives the conversion clock of a 14-bit parallel ADC, captures samples, converts
// offset binary to two's complement (or substitutes a test ramp), packs two
// sign-extended samples per 32-bit beat and emits fixed-length AXI4-Stream packets.
//
// Ports:
//   m00_axis_aclk / m00_axis_areset : sole clock, synchronous active-high reset
//   ADC_data      : ADC output bus, offset binary
//   control       : [0] stream enable, [1] LNA enable, [2] ADC power-down, [3] test ramp
//   ClockToADC    : registered conversion clock, period CLK_DIV, 50% duty
//   LNA_enable, ADC_powerdown : pass-through of control[1], control[2]
//   state         : FSM state (0 idle, 1 arm, 2 stream, 3 drain)
//   overflow      : sticky, a completed sample pair was dropped under backpressure
//   m00_axis_*    : AXI4-Stream master (tstrb constant all-ones)
module adc_to_axis_master #(
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned CLK_DIV                = 4,
  parameter int unsigned FRAME_LEN              = 256
) (
  input  logic                                  m00_axis_aclk,
  input  logic                                  m00_axis_areset,
  input  logic [13:0]                           ADC_data,
  input  logic [3:0]                            control,
  output logic                                  ClockToADC,
  output logic                                  LNA_enable,
  output logic                                  ADC_powerdown,
  output logic [1:0]                            state,
  output logic                                  overflow,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BeatW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0]  DivHalf  = DivW'(CLK_DIV / 2);
  localparam logic [BeatW-1:0] BeatLast = BeatW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArm    = 2'd1,
    StStream = 2'd2,
    StDrain  = 2'd3
  } state_e;

  state_e           state_q;
  logic [DivW-1:0]  div_cnt_q;
  logic             clk_adc_q;
  logic [13:0]      sample_q;
  logic             sample_vld_q;
  logic [13:0]      ramp_q;
  logic [15:0]      hold_q;
  logic             hold_full_q;
  logic [BeatW-1:0] beat_cnt_q;
  logic             tvalid_q;
  logic             tlast_q;
  logic [31:0]      tdata_q;
  logic             overflow_q;

  logic        strobe;
  logic        handshake;
  logic        frame_idle;
  logic        capture;
  logic        pair_ready;
  logic        load;
  logic [13:0] conv;
  logic [15:0] sample_ext;

  always_comb begin
    strobe     = (div_cnt_q == '0);
    handshake  = tvalid_q && m00_axis_tready;
    // Nothing of the current frame is in flight: frame boundary reached.
    frame_idle = (beat_cnt_q == '0) && !hold_full_q && !sample_vld_q;
    // Drain keeps capturing only until the frame in progress is complete.
    capture    = strobe && (((state_q == StArm) && control[0]) ||
                            (state_q == StStream) ||
                            ((state_q == StDrain) && !frame_idle));
    conv       = control[3] ? ramp_q : {~ADC_data[13], ADC_data[12:0]};
    sample_ext = {{2{sample_q[13]}}, sample_q};
    pair_ready = sample_vld_q && hold_full_q;
    load       = pair_ready && (!tvalid_q || handshake);
  end

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state_q      <= StIdle;
      div_cnt_q    <= '0;
      clk_adc_q    <= 1'b0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      ramp_q       <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      beat_cnt_q   <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      div_cnt_q <= (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);
      clk_adc_q <= (div_cnt_q >= DivHalf);

      sample_vld_q <= capture;
      if (capture) begin
        sample_q <= conv;
      end
      if (strobe && ((state_q == StArm) || (state_q == StStream))) begin
        ramp_q <= ramp_q + 14'd1;
      end

      // Even sample fills the hold register; odd sample completes the pair,
      // which is either loaded or dropped. Either way the hold register empties.
      if (sample_vld_q) begin
        if (!hold_full_q) begin
          hold_q      <= sample_ext;
          hold_full_q <= 1'b1;
        end else begin
          hold_full_q <= 1'b0;
          if (!load) begin
            overflow_q <= 1'b1;
          end
        end
      end

      if (load) begin
        tvalid_q   <= 1'b1;
        tdata_q    <= {sample_ext, hold_q};
        tlast_q    <= (beat_cnt_q == BeatLast);
        beat_cnt_q <= (beat_cnt_q == BeatLast) ? '0 : beat_cnt_q + BeatW'(1);
      end else if (handshake) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (control[0]) begin
            state_q     <= StArm;
            overflow_q  <= 1'b0;
            hold_full_q <= 1'b0;
          end
        end
        StArm: begin
          if (!control[0]) begin
            state_q <= StIdle;
          end else if (strobe) begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (!control[0]) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (frame_idle && !tvalid_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ClockToADC      = clk_adc_q;
  assign LNA_enable      = control[1];
  assign ADC_powerdown   = control[2];
  assign state           = state_q;
  assign overflow        = overflow_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = '1;

endmodule
